dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles the block SHALL wait for a bus_rvalid before aborting a read.
REQ-002 clk  input  1  pipeline clock; all state SHALL change on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 MemReadM  input  1  a load is in the Memory stage.
REQ-005 MemWriteM  input  1  a store is in the Memory stage; if MemReadM is also 1, the store SHALL take priority.
REQ-006 ALUOutM  input  32  byte address of the access.
REQ-007 WriteDataM  input  32  store data.
REQ-008 ReadDataM  output  32  load data delivered to the Memory/Writeback register.
REQ-009 StallM  output  1  when 1, the pipeline SHALL hold the Fetch, Decode, Execute and Memory stages.
REQ-010 MemFault  output  1  sticky error flag.
REQ-011 FaultClr  input  1  synchronous clear of MemFault.
REQ-012 bus_req, bus_we  output  1 each  request valid; write enable.
REQ-013 bus_addr, bus_wdata  output  32 each  word address (bits [1:0] = 00); write data.
REQ-014 bus_gnt  input  1  the bus accepts the request in this cycle.
REQ-015 bus_rvalid, bus_err  input  1 each  read data valid; error, sampled together with the completing event.
REQ-016 bus_rdata  input  32  read data.

Function
REQ-017 The FSM SHALL have four states: IDLE, REQ, WAIT and DONE.
REQ-018 IDLE: StallM SHALL equal (MemReadM | MemWriteM), combinationally.
REQ-019 IDLE, on an aligned access (ALUOutM[1:0] = 00): the block SHALL latch the address, data and write flag, and go to REQ.
REQ-020 IDLE, on a misaligned access: the block SHALL not raise bus_req, SHALL set MemFault, SHALL load 0 into the read-data register, and SHALL go to DONE.
REQ-021 REQ: bus_req SHALL be 1, and bus_addr, bus_wdata and bus_we SHALL be driven from the latched values, held stable until bus_gnt is 1.
REQ-022 REQ, on bus_gnt for a write: the block SHALL go to DONE; bus_err SHALL set MemFault.
REQ-023 REQ, on bus_gnt for a read without bus_rvalid: the block SHALL go to WAIT and clear the timeout counter.
REQ-024 REQ, on bus_gnt together with bus_rvalid for a read: the block SHALL capture the data as in REQ-025 and go directly to DONE.
REQ-025 WAIT, on bus_rvalid: the read-data register SHALL load bus_rdata, or 0 if bus_err is 1 (bus_err also sets MemFault); the block SHALL go to DONE.
REQ-026 WAIT, no bus_rvalid: the 8-bit-or-wider counter SHALL increment; when it reaches TIMEOUT, the block SHALL set MemFault, load 0 and go to DONE.
REQ-027 StallM SHALL be 1 in REQ and WAIT, and 0 in DONE.
REQ-028 DONE SHALL last exactly one cycle and then return to IDLE; the pipeline advances on that edge, so the same access is never reissued.
REQ-029 ReadDataM SHALL always equal the read-data register, which changes only on read completion (REQ-020, REQ-024, REQ-025, REQ-026).
REQ-030 bus_req SHALL be 0 in IDLE, WAIT and DONE.
REQ-031 bus_rvalid or bus_gnt in IDLE or DONE SHALL be ignored, with no state, data or fault change.
REQ-032 bus_rvalid in REQ before bus_gnt SHALL be ignored.
REQ-033 Minimum occupancy in the Memory stage: write 3 cycles (IDLE, REQ with gnt, DONE); read with bus_rvalid one cycle after bus_gnt 4 cycles.
REQ-034 Every access SHALL take at most TIMEOUT + 3 cycles after grant.
REQ-035 When FaultClr and a new fault occur in the same cycle, the set SHALL win.

Reset
REQ-036 While reset = 0, asynchronously: state = IDLE, bus_req = 0, bus_we = 0, bus_addr = 0, bus_wdata = 0, read-data register = 0 (ReadDataM = 0), MemFault = 0, counter = 0.
REQ-037 In IDLE with no access during reset, StallM SHALL be 0.
REQ-038 Reset asserted mid-access (REQ or WAIT) SHALL drop bus_req in the same cycle and discard the access; a late bus_rvalid after reset release SHALL be ignored per REQ-031.

Verification
REQ-039 Store: MemWriteM = 1, ALUOutM = 0x100, WriteDataM = 0xDEADBEEF, bus_gnt = 1 in the first REQ cycle -> bus_req and bus_we high for one cycle with bus_addr = 0x100; StallM = 1,1,0 over 3 cycles; MemFault = 0.
REQ-040 Load: MemReadM = 1, ALUOutM = 0x40, bus_gnt after 2 cycles, bus_rvalid 3 cycles later with bus_rdata = 0x12345678 -> ReadDataM = 0x12345678 in DONE; StallM low only in DONE.
REQ-041 Misaligned: MemReadM = 1, ALUOutM = 0x42 -> no bus_req; DONE on the next cycle; ReadDataM = 0; MemFault = 1 until FaultClr.
REQ-042 Timeout: TIMEOUT = 4, read granted, bus_rvalid never asserted -> DONE after 4 WAIT cycles; MemFault = 1; ReadDataM = 0; a later stray bus_rvalid is ignored.
REQ-043 Reset in WAIT: reset = 0 while in WAIT -> bus_req = 0 and StallM = 0 immediately; after release, bus_rvalid with 0xAAAA5555 leaves ReadDataM = 0.
REQ-044 Back-to-back: a load then a store in consecutive instructions -> two distinct bus transactions, with no duplicate request in the DONE to IDLE cycle.

Source files
------------

// File: rtl/dmem_ctrl_if.sv
// Data-memory bus between the load/store controller and memory.
// master: req/we/addr/wdata out; slave: gnt/rvalid/err/rdata out.
interface dmem_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic        bus_err;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_err, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_gnt, bus_rvalid, bus_err, bus_rdata
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Memory-stage load/store controller: IDLE/REQ/WAIT/DONE bus FSM.
// Ports: clk, reset(n), pipeline Mem* in, ReadDataM/StallM/MemFault out, bus master.
module dmem_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MemFault,
  input  logic        FaultClr,
  dmem_ctrl_if.master bus
);

  localparam int CLW = $clog2(TIMEOUT + 1);
  localparam int CW  = (CLW > 8) ? CLW : 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   rdata_q;
  logic          access;
  logic          aligned;
  logic          cnt_last;

  assign access    = MemReadM | MemWriteM;
  assign aligned   = (ALUOutM[1:0] == 2'b00);
  assign cnt_last  = ((cnt + CW'(1)) == CW'(TIMEOUT));
  assign ReadDataM = rdata_q;

  // Gated by reset so the pipeline is released while reset is held.
  always_comb begin
    StallM = 1'b0;
    unique case (state)
      IDLE:     StallM = access;
      REQ:      StallM = 1'b1;
      WAIT:     StallM = 1'b1;
      default:  StallM = 1'b0;
    endcase
    StallM = StallM & reset;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      rdata_q       <= '0;
      MemFault      <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
    end else begin
      // Any fault set below overrides this clear.
      if (FaultClr) MemFault <= 1'b0;
      unique case (state)
        IDLE: begin
          if (access) begin
            if (aligned) begin
              state         <= REQ;
              bus.bus_req   <= 1'b1;
              bus.bus_we    <= MemWriteM;
              bus.bus_addr  <= {ALUOutM[31:2], 2'b00};
              bus.bus_wdata <= WriteDataM;
            end else begin
              MemFault <= 1'b1;
              rdata_q  <= '0;
              state    <= DONE;
            end
          end
        end
        REQ: begin
          if (bus.bus_gnt) begin
            bus.bus_req <= 1'b0;
            bus.bus_we  <= 1'b0;
            if (bus.bus_we) begin
              if (bus.bus_err) MemFault <= 1'b1;
              state <= DONE;
            end else if (bus.bus_rvalid) begin
              rdata_q <= bus.bus_err ? '0 : bus.bus_rdata;
              if (bus.bus_err) MemFault <= 1'b1;
              state <= DONE;
            end else begin
              cnt   <= '0;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.bus_rvalid) begin
            rdata_q <= bus.bus_err ? '0 : bus.bus_rdata;
            if (bus.bus_err) MemFault <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt_last) begin
              MemFault <= 1'b1;
              rdata_q  <= '0;
              state    <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: vector table, corner sequences,
// and random accesses against a cycle-count reference model.
module tb_dmem_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM, FaultClr;
  logic [31:0] ALUOutM, WriteDataM, ReadDataM;
  logic        StallM, MemFault;

  dmem_ctrl_if bus ();

  dmem_ctrl #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MemFault   (MemFault),
    .FaultClr   (FaultClr),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gd;
    int          rv;
    logic        err;
    logic [31:0] data;
    logic        clr;
    int          e_cyc;
    int          e_req;
    logic [31:0] e_rd;
    logic        e_flt;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] m_rdata = '0;
  logic        m_fault = 1'b0;
  vec_t        tbl[10];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    logic nf = 1'b0;
    int   w = 0;
    r.e_rd = m_rdata;
    if (v.addr[1:0] != 2'b00) begin
      r.e_cyc = 2; r.e_req = 0;
      r.e_rd = '0; nf = 1'b1;
    end else if (v.wr) begin
      r.e_cyc = v.gd + 3;
      r.e_req = v.gd + 1;
      nf = v.err;
    end else begin
      r.e_req = v.gd + 1;
      if (v.rv <= TO) begin
        w = v.rv;
        r.e_rd = v.err ? 32'h0 : v.data;
        nf = v.err;
      end else begin
        w = TO; r.e_rd = '0; nf = 1'b1;
      end
      r.e_cyc = v.gd + 3 + w;
    end
    r.e_flt = m_fault | nf;
    return r;
  endfunction

  task automatic bus_idle();
    bus.bus_gnt    = 1'b0;
    bus.bus_rvalid = 1'b0;
    bus.bus_err    = 1'b0;
    bus.bus_rdata  = $urandom();
  endtask

  task automatic clear_fault();
    FaultClr = 1'b1;
    @(posedge clk); #1;
    FaultClr = 1'b0;
    m_fault = 1'b0;
    chk("fault_clr", 32'(MemFault), 32'h0);
  endtask

  task automatic run(input vec_t v, input logic noise,
                     output int cyc, output int reqs,
                     output int bad, output logic [31:0] rd,
                     output logic flt);
    logic done = 1'b0;
    logic granted = 1'b0;
    int   post = 0;
    cyc = 0; reqs = 0; bad = 0;
    rd = '0; flt = 1'b0;
    MemReadM   = v.rd;
    MemWriteM  = v.wr;
    ALUOutM    = v.addr;
    WriteDataM = v.wdata;
    bus_idle();
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.bus_req) begin
        reqs++;
        if (bus.bus_addr !== {v.addr[31:2], 2'b00} ||
            bus.bus_we !== v.wr ||
            (v.wr && bus.bus_wdata !== v.wdata))
          bad++;
      end
      if (!StallM) begin
        done = 1'b1;
        rd = ReadDataM;
        flt = MemFault;
      end
      bus_idle();
      if (done) begin
        bus.bus_gnt = noise;
        bus.bus_rvalid = noise;
      end else if (bus.bus_req) begin
        if (reqs == v.gd + 1) begin
          bus.bus_gnt = 1'b1;
          granted = 1'b1;
          post = 0;
          if (v.wr) bus.bus_err = v.err;
          else if (v.rv == 0) begin
            bus.bus_rvalid = 1'b1;
            bus.bus_err = v.err;
            bus.bus_rdata = v.data;
          end
        end else begin
          bus.bus_rvalid = noise;
        end
      end else if (granted) begin
        post++;
        if (post == v.rv) begin
          bus.bus_rvalid = 1'b1;
          bus.bus_err = v.err;
          bus.bus_rdata = v.data;
        end
      end else begin
        bus.bus_gnt = noise;
        bus.bus_rvalid = noise;
      end
    end
    @(posedge clk); #1;
    MemReadM = 1'b0;
    MemWriteM = 1'b0;
    bus_idle();
  endtask

  task automatic apply(input vec_t v, input logic noise,
                       input string tag);
    int          cyc, reqs, bad;
    logic [31:0] rd;
    logic        flt;
    run(v, noise, cyc, reqs, bad, rd, flt);
    chk({tag, ".cycles"}, 32'(cyc), 32'(v.e_cyc));
    chk({tag, ".reqs"}, 32'(reqs), 32'(v.e_req));
    chk({tag, ".bus"}, 32'(bad), 32'h0);
    chk({tag, ".rdata"}, rd, v.e_rd);
    chk({tag, ".fault"}, 32'(flt), 32'(v.e_flt));
    m_rdata = v.e_rd;
    m_fault = v.e_flt;
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{0, 1, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0,
               3, 1, 32'h0, 0};
    tbl[1] = '{1, 0, 32'h40, 0, 2, 3, 0, 32'h12345678, 0,
               8, 3, 32'h12345678, 0};
    tbl[2] = '{0, 1, 32'h104, 32'h0BADF00D, 0, 0, 0, 0, 0,
               3, 1, 32'h12345678, 0};
    tbl[3] = '{1, 0, 32'h44, 0, 0, 0, 0, 32'hCAFEF00D, 0,
               3, 1, 32'hCAFEF00D, 0};
    tbl[4] = '{1, 0, 32'h48, 0, 0, 1, 0, 32'h11112222, 0,
               4, 1, 32'h11112222, 0};
    tbl[5] = '{0, 1, 32'h60, 32'h55AA55AA, 1, 0, 1, 0, 0,
               4, 2, 32'h11112222, 1};
    tbl[6] = '{1, 0, 32'h42, 0, 0, 0, 0, 0, 1,
               2, 0, 32'h0, 1};
    tbl[7] = '{1, 0, 32'h50, 0, 0, 9, 0, 32'h77777777, 1,
               7, 1, 32'h0, 1};
    tbl[8] = '{1, 0, 32'h64, 0, 0, 2, 1, 32'h99999999, 1,
               5, 1, 32'h0, 1};
    tbl[9] = '{1, 0, 32'h70, 0, 3, 2, 0, 32'hA5A5F00F, 1,
               8, 4, 32'hA5A5F00F, 0};

    reset = 1'b0;
    MemReadM = 1'b0; MemWriteM = 1'b0;
    ALUOutM = '0; WriteDataM = '0; FaultClr = 1'b0;
    bus_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req", 32'(bus.bus_req), 32'h0);
    chk("rst.we", 32'(bus.bus_we), 32'h0);
    chk("rst.addr", bus.bus_addr, 32'h0);
    chk("rst.wdata", bus.bus_wdata, 32'h0);
    chk("rst.rdata", ReadDataM, 32'h0);
    chk("rst.fault", 32'(MemFault), 32'h0);
    chk("rst.stall", 32'(StallM), 32'h0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].clr) clear_fault();
      apply(tbl[i], 1'(i % 2), $sformatf("tbl%0d", i));
    end

    // stray bus activity while idle must not disturb anything
    for (int i = 0; i < 3; i++) begin
      bus.bus_gnt = 1'b1;
      bus.bus_rvalid = 1'b1;
      bus.bus_err = 1'b1;
      bus.bus_rdata = 32'hBAD0BAD0;
      @(negedge clk);
      chk("stray.rdata", ReadDataM, m_rdata);
      chk("stray.req", 32'(bus.bus_req), 32'h0);
      chk("stray.stall", 32'(StallM), 32'h0);
      @(posedge clk); #1;
    end
    bus_idle();

    // fault clear and a new fault in the same cycle: set wins
    FaultClr = 1'b1;
    v = '{1, 0, 32'h13, 0, 0, 0, 0, 0, 0, 2, 0, 32'h0, 1};
    apply(v, 1'b0, "setwin");
    FaultClr = 1'b0;
    m_fault = 1'b0;
    chk("setwin.after", 32'(MemFault), 32'h0);

    // reset while a read waits for data
    MemReadM = 1'b1; ALUOutM = 32'h80;
    @(negedge clk);
    @(negedge clk) bus.bus_gnt = 1'b1;
    @(posedge clk); #1 bus.bus_gnt = 1'b0;
    @(negedge clk);
    chk("rstw.stall_pre", 32'(StallM), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("rstw.req", 32'(bus.bus_req), 32'h0);
    chk("rstw.stall", 32'(StallM), 32'h0);
    chk("rstw.rdata", ReadDataM, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1; MemReadM = 1'b0;
    m_rdata = '0; m_fault = 1'b0;
    bus.bus_rvalid = 1'b1;
    bus.bus_rdata = 32'hAAAA5555;
    repeat (2) begin
      @(negedge clk);
      chk("rstw.late_rd", ReadDataM, 32'h0);
      chk("rstw.late_st", 32'(StallM), 32'h0);
      @(posedge clk); #1;
    end
    bus_idle();

    // reset while the request is still outstanding
    MemWriteM = 1'b1; ALUOutM = 32'h90;
    @(negedge clk);
    @(negedge clk);
    chk("rstr.req_pre", 32'(bus.bus_req), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("rstr.req", 32'(bus.bus_req), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1; MemWriteM = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = $urandom();
      if ($urandom_range(7) != 0) a[1:0] = 2'b00;
      else if (a[1:0] == 2'b00) a[0] = 1'b1;
      v.wr = 1'($urandom_range(1));
      v.rd = v.wr ? 1'($urandom_range(1)) : 1'b1;
      v.addr = a;
      v.wdata = $urandom();
      v.gd = $urandom_range(3);
      v.rv = $urandom_range(6);
      v.err = ($urandom_range(5) == 0);
      v.data = $urandom();
      v.clr = ($urandom_range(3) == 0);
      if (v.clr) clear_fault();
      v = model(v);
      apply(v, 1'($urandom_range(1)), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
